// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC plus one-outstanding IM_REQ/IM_ACK handshake; INSTR is valid 1 cycle after a clean IM_ACK.
// STALL freezes the VALID state; BR_TAKEN redirects fetch and flushes or squashes whatever is in flight.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IM_REQ,
  output logic [ADDR_W-1:0] IM_ADDR,
  input  logic              IM_ACK,
  input  logic [31:0]       IM_RDATA,
  input  logic              STALL,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  output logic [31:0]       INSTR,
  output logic [5:0]        OPCODE,
  output logic [4:0]        RS,
  output logic [4:0]        RT,
  output logic [4:0]        RD,
  output logic [5:0]        FUNCT,
  output logic [15:0]       IMM16,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              INSTR_VALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] br_pc;

  assign br_pc = {BR_TARGET[ADDR_W-1:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    squash_d = squash_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (IM_ACK) begin
          if (squash_q || BR_TAKEN) begin
            // Returned word belongs to the abandoned path: drop it and re-request.
            squash_d = 1'b0;
            pc_d     = BR_TAKEN ? br_pc : pc_q;
            addr_d   = BR_TAKEN ? br_pc : pc_q;
          end else begin
            instr_d  = IM_RDATA;
            pc_out_d = pc_q;
            pc_d     = pc_q + ADDR_W'(4);
            valid_d  = 1'b1;
            state_d  = VALID;
          end
        end else if (BR_TAKEN) begin
          // Request already on the bus keeps its address; remember to squash its data.
          pc_d     = br_pc;
          squash_d = 1'b1;
        end
      end
      VALID: begin
        if (BR_TAKEN) begin
          instr_d = '0;
          valid_d = 1'b0;
          pc_d    = br_pc;
          addr_d  = br_pc;
          state_d = FETCH;
        end else if (!STALL) begin
          instr_d = '0;
          valid_d = 1'b0;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign IM_REQ      = (state_q == FETCH);
  assign IM_ADDR     = addr_q;
  assign INSTR       = instr_q;
  assign PC_OUT      = pc_out_q;
  assign INSTR_VALID = valid_q;
  assign OPCODE      = instr_q[31:26];
  assign RS          = instr_q[25:21];
  assign RT          = instr_q[20:16];
  assign RD          = instr_q[15:11];
  assign FUNCT       = instr_q[5:0];
  assign IMM16       = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected fetched words.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic        instr_valid;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst),
    .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_ACK(im_ack), .IM_RDATA(im_rdata),
    .STALL(stall), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
    .INSTR(instr), .OPCODE(opcode), .RS(rs), .RT(rt), .RD(rd),
    .FUNCT(funct), .IMM16(imm16), .PC_OUT(pc_out), .INSTR_VALID(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.instr = w;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  // Pop and compare on every rising INSTR_VALID.
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid && !prev_valid) begin
      check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("instr",  instr,           e.instr);
        check("pc_out", pc_out,          e.pc);
        check("opcode", 32'(opcode),     32'(e.instr[31:26]));
        check("rs",     32'(rs),         32'(e.instr[25:21]));
        check("rt",     32'(rt),         32'(e.instr[20:16]));
        check("rd",     32'(rd),         32'(e.instr[15:11]));
        check("funct",  32'(funct),      32'(e.instr[5:0]));
        check("imm16",  32'(imm16),      32'(e.instr[15:0]));
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; im_ack = 1'b0; im_rdata = '0; stall = 1'b0;
    br_taken = 1'b0; br_target = '0;
    step(); step();
    check("rst_req",    32'(im_req), 32'd0);
    check("rst_addr",   im_addr,     32'h0);
    check("rst_instr",  instr,       32'h0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_pc_out", pc_out,      32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait memory: three back-to-back fetches.
    check("zw_req0",   32'(im_req), 32'd1);
    check("zw_addr0",  im_addr,     32'h0);
    check("zw_vld0",   32'(instr_valid), 32'd0);
    im_ack = 1'b1; im_rdata = 32'h8C00_0004; push(32'h8C00_0004, 32'h0);
    step();
    check("zw_vld1",   32'(instr_valid), 32'd1);
    check("zw_op1",    32'(opcode), 32'h23);
    check("zw_req1",   32'(im_req), 32'd0);
    im_rdata = 32'h0000_0020;
    step();
    check("zw_addr4",  im_addr,     32'h4);
    check("zw_vld2",   32'(instr_valid), 32'd0);
    push(32'h0000_0020, 32'h4);
    step();
    check("zw_vld3",   32'(instr_valid), 32'd1);
    check("zw_funct",  32'(funct),  32'h20);
    im_rdata = 32'h1000_0003;
    step();
    check("zw_addr8",  im_addr,     32'h8);
    check("zw_vld4",   32'(instr_valid), 32'd0);
    push(32'h1000_0003, 32'h8);
    step();
    check("zw_vld5",   32'(instr_valid), 32'd1);
    check("zw_op3",    32'(opcode), 32'h04);
    im_ack = 1'b0;
    step();

    // Three wait cycles, then ACK in the fourth request cycle.
    for (int i = 0; i < 3; i++) begin
      check("wait_req",  32'(im_req), 32'd1);
      check("wait_addr", im_addr,     32'hC);
      check("wait_vld",  32'(instr_valid), 32'd0);
      step();
    end
    check("wait_req4",  32'(im_req), 32'd1);
    check("wait_addr4", im_addr,     32'hC);
    im_ack = 1'b1; im_rdata = 32'hAAAA_5555; push(32'hAAAA_5555, 32'hC);
    step();
    im_ack = 1'b0;
    check("wait_lat1", 32'(instr_valid), 32'd1);

    // Five stalled cycles hold everything.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_vld",   32'(instr_valid), 32'd1);
      check("stall_instr", instr,  32'hAAAA_5555);
      check("stall_pc",    pc_out, 32'hC);
      check("stall_req",   32'(im_req), 32'd0);
    end
    stall = 1'b0;
    step();
    check("resume_req",  32'(im_req), 32'd1);
    check("resume_addr", im_addr,     32'h10);
    check("resume_vld",  32'(instr_valid), 32'd0);

    // Branch while a request at 0x10 is outstanding; its data must be squashed.
    br_taken = 1'b1; br_target = 32'h103;
    step();
    br_taken = 1'b0;
    check("sq_addr_hold1", im_addr,     32'h10);
    check("sq_req1",       32'(im_req), 32'd1);
    step();
    check("sq_addr_hold2", im_addr,     32'h10);
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    step();
    check("sq_vld",   32'(instr_valid), 32'd0);
    check("sq_instr", instr,            32'h0);
    check("sq_req",   32'(im_req),      32'd1);
    check("sq_addr",  im_addr,          32'h100);
    im_rdata = 32'h1234_5678; push(32'h1234_5678, 32'h100);
    step();
    im_ack = 1'b0;
    check("br_vld_pre", 32'(instr_valid), 32'd1);

    // Branch during VALID with STALL high: branch wins.
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h40;
    step();
    stall = 1'b0; br_taken = 1'b0;
    check("brv_vld",   32'(instr_valid), 32'd0);
    check("brv_instr", instr,            32'h0);
    check("brv_req",   32'(im_req),      32'd1);
    check("brv_addr",  im_addr,          32'h40);

    // ACK and BR in the same cycle to an unaligned target near the top.
    im_ack = 1'b1; im_rdata = 32'hBAD0_BAD0; br_taken = 1'b1; br_target = 32'hFFFF_FFFE;
    step();
    br_taken = 1'b0;
    check("wrap_addr", im_addr, 32'hFFFF_FFFC);
    check("wrap_vld0", 32'(instr_valid), 32'd0);
    im_rdata = 32'h2401_0001; push(32'h2401_0001, 32'hFFFF_FFFC);
    step();
    im_ack = 1'b0;
    check("wrap_vld1", 32'(instr_valid), 32'd1);
    step();
    check("wrap_next", im_addr, 32'h0);
    im_ack = 1'b1; im_rdata = 32'h0022_0820; push(32'h0022_0820, 32'h0);
    step();
    im_ack = 1'b0;
    step();
    check("pre_rst_addr", im_addr,     32'h4);
    check("pre_rst_req",  32'(im_req), 32'd1);

    // Reset in the middle of an outstanding request.
    rst = 1'b1;
    step();
    check("mrst_req",   32'(im_req), 32'd0);
    check("mrst_addr",  im_addr,     32'h0);
    check("mrst_vld",   32'(instr_valid), 32'd0);
    check("mrst_pcout", pc_out,      32'h0);
    rst = 1'b0;
    step();
    check("post_rst_req",  32'(im_req), 32'd1);
    check("post_rst_addr", im_addr,     32'h0);
    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
